// File: rtl/operand_issuer_pkg.sv
// Shared types and defaults for the operand issuer: FSM states, error codes
// and the valid-prefix helper used to count usable accumulator operands.
package operand_issuer_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_PC_W        = 12;
    localparam int DEF_OPC_W       = 4;
    localparam int DEF_TIMEOUT_CYC = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        CLEAR = 3'd4,
        ERR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_TIMEOUT   = 2'd2
    } err_code_t;

    // Operands are only usable as a contiguous prefix from r0; a hole ends the count.
    function automatic logic [1:0] prefix_avail(input logic [2:0] vld);
        logic [1:0] cnt;
        casez (vld)
            3'b111:  cnt = 2'd3;
            3'b?11:  cnt = 2'd2;
            3'b??1:  cnt = 2'd1;
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/operand_issuer_timer.sv
// Wait-phase cycle counter: cleared outside WAIT, counts while enabled and
// flags expiry on its last allowed value.
module issue_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            TW   = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] count_r;
    logic          expired_s;

    // Expiry decode of the current count.
    always_comb begin
        expired_s = (count_r == LAST);
    end

    // Counter saturates at the expiry value so it can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {TW{1'b0}};
        end else if (clr) begin
            count_r <= {TW{1'b0}};
        end else if (en && !expired_s) begin
            count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = expired_s;

endmodule

// File: rtl/operand_issuer.sv
// Consumer side of the operand accumulator: checks operand availability,
// issues to the ALU over valid/ready, waits for the result and clears the accumulator.
module operand_issuer
    import operand_issuer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int PC_W        = DEF_PC_W,
    parameter int OPC_W       = DEF_OPC_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_req,
    input  logic [OPC_W-1:0]  op_code,
    input  logic [1:0]        op_nargs,
    input  logic [PC_W-1:0]   prog_ctr,
    input  logic [DATA_W-1:0] r0,
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] r2,
    input  logic              r0_valid,
    input  logic              r1_valid,
    input  logic              r2_valid,
    input  logic              alu_ready,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              alu_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_c,
    output logic [OPC_W-1:0]  alu_op,
    output logic              acc_op_en,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic [1:0]        err_code
);

    state_t            state_r;
    logic [PC_W-1:0]   last_pc_r;
    logic [1:0]        nargs_r;
    logic              alu_valid_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [DATA_W-1:0] alu_c_r;
    logic [OPC_W-1:0]  alu_op_r;
    logic              acc_op_en_r;
    logic              busy_r;
    logic              result_valid_r;
    logic [DATA_W-1:0] result_r;
    logic              err_r;
    err_code_t         err_code_r;

    logic [1:0]        avail_s;
    logic              pass_s;
    logic              new_pc_s;
    logic              tmr_clr_s;
    logic              tmr_en_s;
    logic              tmr_expired_s;

    // Operand availability, PC dedupe and timer control decode.
    always_comb begin
        avail_s   = prefix_avail({r2_valid, r1_valid, r0_valid});
        pass_s    = (avail_s >= nargs_r);
        new_pc_s  = (prog_ctr != last_pc_r);
        tmr_clr_s = (state_r != WAIT);
        tmr_en_s  = (state_r == WAIT);
    end

    issue_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // Control FSM; every output is a register, pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            last_pc_r      <= {PC_W{1'b1}};
            nargs_r        <= 2'd0;
            alu_valid_r    <= 1'b0;
            alu_a_r        <= {DATA_W{1'b0}};
            alu_b_r        <= {DATA_W{1'b0}};
            alu_c_r        <= {DATA_W{1'b0}};
            alu_op_r       <= {OPC_W{1'b0}};
            acc_op_en_r    <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            result_r       <= {DATA_W{1'b0}};
            err_r          <= 1'b0;
            err_code_r     <= ERR_NONE;
        end else begin
            acc_op_en_r    <= 1'b0;
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (op_req && new_pc_s) begin
                        alu_op_r  <= op_code;
                        nargs_r   <= op_nargs;
                        last_pc_r <= prog_ctr;
                        busy_r    <= 1'b1;
                        state_r   <= CHECK;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CHECK: begin
                    if (pass_s) begin
                        alu_a_r     <= (nargs_r >= 2'd1) ? r0 : {DATA_W{1'b0}};
                        alu_b_r     <= (nargs_r >= 2'd2) ? r1 : {DATA_W{1'b0}};
                        alu_c_r     <= (nargs_r == 2'd3) ? r2 : {DATA_W{1'b0}};
                        alu_valid_r <= 1'b1;
                        state_r     <= ISSUE;
                    end else begin
                        err_r       <= 1'b1;
                        err_code_r  <= ERR_UNDERFLOW;
                        acc_op_en_r <= 1'b1;
                        state_r     <= ERR;
                    end
                end
                ISSUE: begin
                    if (alu_ready) begin
                        alu_valid_r <= 1'b0;
                        state_r     <= WAIT;
                    end else begin
                        state_r     <= ISSUE;
                    end
                end
                WAIT: begin
                    // A done strobe on the expiry cycle still delivers the result.
                    if (alu_done) begin
                        result_r       <= alu_result;
                        result_valid_r <= 1'b1;
                        acc_op_en_r    <= 1'b1;
                        state_r        <= CLEAR;
                    end else if (tmr_expired_s) begin
                        err_r          <= 1'b1;
                        err_code_r     <= ERR_TIMEOUT;
                        acc_op_en_r    <= 1'b1;
                        state_r        <= ERR;
                    end else begin
                        state_r        <= WAIT;
                    end
                end
                CLEAR: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                ERR: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    alu_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign alu_valid    = alu_valid_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_c        = alu_c_r;
    assign alu_op       = alu_op_r;
    assign acc_op_en    = acc_op_en_r;
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign result       = result_r;
    assign err          = err_r;
    assign err_code     = err_code_r;

endmodule

// File: tb/tb_operand_issuer.sv
// Directed plus randomized bench for operand_issuer; expectations come from a
// transaction-level timeline model of each op.
module tb_operand_issuer;

    localparam int DW = 8;
    localparam int PW = 12;
    localparam int OW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_req = 1'b0;
    logic [OW-1:0] op_code = '0;
    logic [1:0]    op_nargs = '0;
    logic [PW-1:0] prog_ctr = '0;
    logic [DW-1:0] r0 = '0, r1 = '0, r2 = '0;
    logic          r0_valid = 1'b0, r1_valid = 1'b0, r2_valid = 1'b0;
    logic          alu_ready = 1'b0, alu_done = 1'b0;
    logic [DW-1:0] alu_result = '0;
    logic          alu_valid;
    logic [DW-1:0] alu_a, alu_b, alu_c;
    logic [OW-1:0] alu_op;
    logic          acc_op_en, busy, result_valid, err;
    logic [DW-1:0] result;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_fails  = 0;

    operand_issuer #(
        .DATA_W(DW), .PC_W(PW), .OPC_W(OW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op_req(op_req), .op_code(op_code),
        .op_nargs(op_nargs), .prog_ctr(prog_ctr), .r0(r0), .r1(r1), .r2(r2),
        .r0_valid(r0_valid), .r1_valid(r1_valid), .r2_valid(r2_valid),
        .alu_ready(alu_ready), .alu_done(alu_done), .alu_result(alu_result),
        .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_op(alu_op), .acc_op_en(acc_op_en), .busy(busy),
        .result_valid(result_valid), .result(result), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_valid"},    32'(alu_valid),    32'd0);
        check({tag, ".alu_a"},        32'(alu_a),        32'd0);
        check({tag, ".alu_b"},        32'(alu_b),        32'd0);
        check({tag, ".alu_c"},        32'(alu_c),        32'd0);
        check({tag, ".alu_op"},       32'(alu_op),       32'd0);
        check({tag, ".acc_op_en"},    32'(acc_op_en),    32'd0);
        check({tag, ".busy"},         32'(busy),         32'd0);
        check({tag, ".result_valid"}, 32'(result_valid), 32'd0);
        check({tag, ".result"},       32'(result),       32'd0);
        check({tag, ".err"},          32'(err),          32'd0);
        check({tag, ".err_code"},     32'(err_code),     32'd0);
    endtask

    // Number of leading valid operands starting from r0.
    function automatic int avail_of(input logic [2:0] v);
        int k = 0;
        while (k < 3 && v[k]) k++;
        return k;
    endfunction

    // One op: request before edge 0, ready seen at edge 2+dr, done at edge 3+dr+dd
    // (dd >= TO means the ALU never answers). Checks every cycle until back in IDLE.
    task automatic run_op(input logic [PW-1:0] pc, input logic [OW-1:0] opc, input int nargs,
                          input logic [2:0] vld, input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                          input logic [DW-1:0] rc, input int dr, input int dd, input logic [DW-1:0] res);
        logic [DW-1:0] ops [3];
        bit und, ev, erv, eerr;
        int end_e;
        ops[0] = (nargs > 0) ? ra : '0;
        ops[1] = (nargs > 1) ? rb : '0;
        ops[2] = (nargs > 2) ? rc : '0;
        und    = (nargs > avail_of(vld));
        end_e  = und ? 1 : ((dd < TO) ? 3 + dr + dd : 3 + dr + TO - 1);
        for (int n = 0; n <= end_e + 1; n++) begin
            op_req   = (n == 0) ? 1'b1 : 1'($urandom);
            op_code  = (n == 0) ? opc : OW'($urandom);
            op_nargs = (n == 0) ? 2'(nargs) : 2'($urandom);
            prog_ctr = (n == 0) ? pc : PW'($urandom);
            if (n == 0) begin
                r0 = ra; r1 = rb; r2 = rc;
                {r2_valid, r1_valid, r0_valid} = vld;
            end else if (n >= 2) begin
                r0 = DW'($urandom); r1 = DW'($urandom); r2 = DW'($urandom);
                {r2_valid, r1_valid, r0_valid} = 3'($urandom);
            end
            alu_ready  = (n >= 2 + dr);
            alu_done   = (!und && n >= 1 && n <= 2 + dr) ? 1'($urandom) : 1'b0;
            alu_result = DW'($urandom);
            if (!und && dd < TO && n == 3 + dr + dd) begin
                alu_done   = 1'b1;
                alu_result = res;
            end
            @(posedge clk); #1;
            ev   = !und && n >= 1 && n < 2 + dr;
            erv  = !und && dd < TO && n == 3 + dr + dd;
            eerr = und ? (n == 1) : (dd >= TO && n == 3 + dr + TO - 1);
            check("alu_valid",    32'(alu_valid),    32'(ev));
            check("result_valid", 32'(result_valid), 32'(erv));
            check("err",          32'(err),          32'(eerr));
            check("acc_op_en",    32'(acc_op_en),    32'(erv || eerr));
            check("busy",         32'(busy),         32'(n <= end_e));
            if (ev) begin
                check("alu_a",  32'(alu_a),  32'(ops[0]));
                check("alu_b",  32'(alu_b),  32'(ops[1]));
                check("alu_c",  32'(alu_c),  32'(ops[2]));
                check("alu_op", 32'(alu_op), 32'(opc));
            end
            if (erv)  check("result",   32'(result),   32'(res));
            if (eerr) check("err_code", 32'(err_code), und ? 32'd1 : 32'd2);
        end
        op_req = 1'b0; alu_ready = 1'b0; alu_done = 1'b0;
    endtask

    // Repeated request with a PC the block must refuse.
    task automatic run_ignored(input logic [PW-1:0] pc);
        for (int n = 0; n < 3; n++) begin
            op_req = 1'b1; prog_ctr = pc; op_nargs = 2'd0; op_code = 4'h1;
            @(posedge clk); #1;
            check("dup.busy",      32'(busy),      32'd0);
            check("dup.alu_valid", 32'(alu_valid), 32'd0);
            check("dup.err",       32'(err),       32'd0);
        end
        op_req = 1'b0;
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(12'h010, 4'h2, 3, 3'b111, 8'd5, 8'd7, 8'd9, 0, 0, 8'h15);
        run_op(12'h011, 4'h3, 2, 3'b001, 8'd1, 8'd2, 8'd3, 0, 0, 8'h00);
        check("result_held", 32'(result), 32'h15);
        run_op(12'h012, 4'h4, 2, 3'b011, 8'hA1, 8'hB2, 8'hC3, 10, 2, 8'h5A);
        check("err_code_held", 32'(err_code), 32'd1);
        run_op(12'h013, 4'h5, 1, 3'b001, 8'h11, 8'h22, 8'h33, 0, TO, 8'h00);
        run_op(12'h014, 4'h6, 1, 3'b111, 8'h12, 8'h34, 8'h56, 1, TO - 1, 8'h77);
        run_op(12'h020, 4'h7, 2, 3'b111, 8'h01, 8'h02, 8'h03, 0, 0, 8'h99);
        run_ignored(12'h020);
        run_op(12'h021, 4'h8, 3, 3'b111, 8'h04, 8'h05, 8'h06, 2, 1, 8'h42);
        run_op(12'h022, 4'h9, 2, 3'b101, 8'h0A, 8'h0B, 8'h0C, 0, 0, 8'h00);
        run_op(12'h023, 4'hA, 1, 3'b110, 8'h0D, 8'h0E, 8'h0F, 0, 0, 8'h00);
        run_op(12'h024, 4'hB, 0, 3'b000, 8'hEE, 8'hDD, 8'hCC, 0, 0, 8'h3C);

        for (int i = 0; i < 25; i++) begin
            run_op(PW'(12'h100 + i), OW'($urandom), int'($urandom_range(0, 3)), 3'($urandom),
                   DW'($urandom), DW'($urandom), DW'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), DW'($urandom));
        end

        // Reset while waiting on the ALU, then re-request the same PC.
        op_req = 1'b1; prog_ctr = 12'h030; op_code = 4'h3; op_nargs = 2'd1;
        r0 = 8'h44; {r2_valid, r1_valid, r0_valid} = 3'b001;
        alu_ready = 1'b1; alu_done = 1'b0;
        @(posedge clk); #1;
        op_req = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("wait.busy",      32'(busy),      32'd1);
        check("wait.alu_valid", 32'(alu_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        alu_ready = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(12'h030, 4'h3, 1, 3'b001, 8'h44, 8'h00, 8'h00, 0, 0, 8'h88);

        // All-ones PC right after reset matches the reset value of the dedupe register.
        rst_n = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_ignored(12'hFFF);
        run_op(12'hFFE, 4'hF, 3, 3'b111, 8'hFA, 8'hFB, 8'hFC, 0, 0, 8'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
